// File: rtl/dma_memcyc.sv
// dma_memcyc: DMA memory-cycle sequencer. Arbitrates NCH requesters
// round-robin, then runs one ADDR/DATA/END memory cycle for the winner
// with a programmable number of wait states plus external WAIT extension.
// Every output comes straight from a flop.
module dma_memcyc #(
  parameter int NCH = 2,
  parameter int WSW = 3
) (
  input  logic           CLK,
  input  logic           RESETL,
  input  logic [NCH-1:0] REQ,
  input  logic [NCH-1:0] WR,
  input  logic           BAK,
  input  logic           WAIT,
  input  logic [WSW-1:0] WSCNT,
  output logic [NCH-1:0] GNT,
  output logic           MREQL,
  output logic           CYCL,
  output logic           RDL,
  output logic           WRL,
  output logic           DONE,
  output logic           BUSY
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_ADDR,
    S_DATA,
    S_END
  } state_t;

  localparam logic [NCH-1:0] ONE = NCH'(1);
  // "Last granted" is held one-hot; resetting it to the top channel makes
  // the first search begin at channel 0.
  localparam logic [NCH-1:0] LAST_RST = ONE << (NCH - 1);

  state_t         state_q, state_d;
  logic [NCH-1:0] gnt_q, gnt_d;
  logic [NCH-1:0] last_q, last_d;
  logic [WSW-1:0] cnt_q, cnt_d;
  logic           wr_q, wr_d;
  logic [NCH-1:0] above;
  logic [NCH-1:0] pick;
  logic           start;
  logic           mreql_q, cycl_q, rdl_q, wrl_q, done_q, busy_q;

  assign start = (|REQ) & BAK & ~WAIT;

  // Round-robin pick: lowest requester above the last grant, else wrap to lowest overall.
  always_comb begin
    above = REQ & ~(last_q | (last_q - ONE));
    if (above != '0) begin
      pick = above & (~above + ONE);
    end else begin
      pick = REQ & (~REQ + ONE);
    end
  end

  // Next-state logic: cycle sequencing, grant latching and wait-state counting.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ARB;
          gnt_d   = pick;
          last_d  = pick;
        end
      end
      S_ARB: begin
        if (BAK) begin
          // Freeze direction and wait count for the whole cycle.
          state_d = S_ADDR;
          cnt_d   = WSCNT;
          wr_d    = |(WR & gnt_q);
        end else begin
          state_d = S_IDLE;
          gnt_d   = '0;
        end
      end
      S_ADDR: begin
        state_d = S_DATA;
      end
      S_DATA: begin
        // Programmed wait states first, then hold while WAIT at the final count.
        if (cnt_q != '0) begin
          cnt_d = cnt_q - WSW'(1);
        end else if (!WAIT) begin
          state_d = S_END;
        end
      end
      S_END: begin
        if (start) begin
          state_d = S_ARB;
          gnt_d   = pick;
          last_d  = pick;
        end else begin
          state_d = S_IDLE;
          gnt_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // State and registered outputs, decoded from the next state so they align with it.
  always_ff @(posedge CLK) begin
    if (!RESETL) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      last_q  <= LAST_RST;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      mreql_q <= 1'b1;
      cycl_q  <= 1'b1;
      rdl_q   <= 1'b1;
      wrl_q   <= 1'b1;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      mreql_q <= (state_d != S_ADDR);
      cycl_q  <= !((state_d == S_ADDR) || (state_d == S_DATA));
      rdl_q   <= !((state_d == S_DATA) && !wr_d);
      wrl_q   <= !((state_d == S_DATA) && wr_d);
      done_q  <= (state_d == S_END);
      busy_q  <= (state_d != S_IDLE);
    end
  end

  assign GNT   = gnt_q;
  assign MREQL = mreql_q;
  assign CYCL  = cycl_q;
  assign RDL   = rdl_q;
  assign WRL   = wrl_q;
  assign DONE  = done_q;
  assign BUSY  = busy_q;

endmodule

// File: tb/tb_dma_memcyc.sv
// tb_dma_memcyc: directed bench for dma_memcyc. A cycle-level behavioural
// model predicts every output each clock; directed scenarios add literal
// expectations for strobe widths, latencies and grant order.
module tb_dma_memcyc;
  localparam int NCH = 2;
  localparam int WSW = 3;

  logic           CLK = 1'b0;
  logic           RESETL;
  logic [NCH-1:0] REQ, WR;
  logic           BAK, WAIT;
  logic [WSW-1:0] WSCNT;
  logic [NCH-1:0] GNT;
  logic           MREQL, CYCL, RDL, WRL, DONE, BUSY;

  always #5 CLK = ~CLK;

  dma_memcyc #(.NCH(NCH), .WSW(WSW)) dut (
    .CLK(CLK), .RESETL(RESETL), .REQ(REQ), .WR(WR), .BAK(BAK), .WAIT(WAIT),
    .WSCNT(WSCNT), .GNT(GNT), .MREQL(MREQL), .CYCL(CYCL), .RDL(RDL),
    .WRL(WRL), .DONE(DONE), .BUSY(BUSY)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 idle, 1 arbitrating, 2 address, 3 data, 4 end
  int m_phase = 0;
  int m_ch    = -1;
  int m_last  = NCH - 1;
  int m_left  = 0;
  bit m_wr    = 1'b0;

  function automatic int rr_pick(input int last, input logic [NCH-1:0] r);
    logic [NCH-1:0] t;
    for (int k = 1; k <= NCH; k++) begin
      t = r >> ((last + k) % NCH);
      if (t[0]) return (last + k) % NCH;
    end
    return -1;
  endfunction

  initial forever begin
    @(posedge CLK);
    if (!RESETL) begin
      m_phase = 0; m_ch = -1; m_last = NCH - 1; m_left = 0; m_wr = 1'b0;
    end else begin
      automatic bit go = (REQ != '0) && BAK && !WAIT;
      automatic logic [NCH-1:0] wsh;
      case (m_phase)
        0: if (go) begin m_ch = rr_pick(m_last, REQ); m_last = m_ch; m_phase = 1; end
        1: if (BAK) begin
             wsh = WR >> m_ch; m_wr = wsh[0]; m_left = int'(WSCNT) + 1; m_phase = 2;
           end else begin
             m_phase = 0; m_ch = -1;
           end
        2: m_phase = 3;
        3: if (m_left > 1) m_left--; else if (!WAIT) m_phase = 4;
        default: if (go) begin m_ch = rr_pick(m_last, REQ); m_last = m_ch; m_phase = 1; end
                 else begin m_phase = 0; m_ch = -1; end
      endcase
    end
  end

  // ---------------- per-cycle compare and strobe counters ----------------
  bit chk_en = 1'b0;
  int n_mreq, n_cycl, n_rd, n_wr, n_done, n_busy, n_idle;

  task automatic clr();
    n_mreq = 0; n_cycl = 0; n_rd = 0; n_wr = 0; n_done = 0; n_busy = 0; n_idle = 0;
  endtask

  initial forever begin
    @(negedge CLK);
    if (chk_en) begin
      automatic logic [NCH-1:0] eg = '0;
      automatic logic [NCH+5:0] exp_v, act_v;
      if (m_ch >= 0) eg = NCH'(1) << m_ch;
      exp_v = {eg, m_phase != 2, !(m_phase == 2 || m_phase == 3),
               !(m_phase == 3 && !m_wr), !(m_phase == 3 && m_wr),
               m_phase == 4, m_phase != 0};
      act_v = {GNT, MREQL, CYCL, RDL, WRL, DONE, BUSY};
      chk("cycle_outputs", 32'(act_v), 32'(exp_v));
      if (!MREQL) n_mreq++;
      if (!CYCL)  n_cycl++;
      if (!RDL)   n_rd++;
      if (!WRL)   n_wr++;
      if (DONE)   n_done++;
      if (BUSY)   n_busy++; else n_idle++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Wait for DONE (bounded), drop REQ on it, report negedges waited and grant.
  task automatic wait_done(input int budget, output int lat, output logic [NCH-1:0] g);
    lat = 0; g = '0;
    for (int i = 1; i <= budget && lat == 0; i++) begin
      @(negedge CLK);
      if (DONE) begin lat = i; g = GNT; REQ = '0; end
    end
  endtask

  logic [NCH-1:0] g;
  logic [NCH-1:0] gseq [4];
  int lat, nd;

  initial begin
    RESETL = 1'b0; REQ = '0; WR = '0; BAK = 1'b0; WAIT = 1'b0; WSCNT = '0;
    @(posedge CLK);
    chk_en = 1'b1;
    idle(2);
    chk("reset_outputs", 32'({GNT, MREQL, CYCL, RDL, WRL, DONE, BUSY}), 32'h3C);
    RESETL = 1'b1;

    // Single read on channel 0, no wait states.
    clr(); REQ = 2'b01; WR = 2'b00; BAK = 1'b1; WAIT = 1'b0; WSCNT = 3'd0;
    wait_done(20, lat, g);
    idle(3);
    chk("t1_latency", 32'(lat), 32'd4);
    chk("t1_gnt", 32'(g), 32'h1);
    chk("t1_mreql_clocks", 32'(n_mreq), 32'd1);
    chk("t1_cycl_clocks", 32'(n_cycl), 32'd2);
    chk("t1_rdl_clocks", 32'(n_rd), 32'd1);
    chk("t1_wrl_clocks", 32'(n_wr), 32'd0);
    chk("t1_done_count", 32'(n_done), 32'd1);
    $display("txn 1: single read ch0, done after %0d clocks, gnt=%b", lat, g);

    // Write on channel 1, 3 wait states plus 2 WAIT clocks; late WR/WSCNT changes ignored.
    clr(); REQ = 2'b10; WR = 2'b10; WSCNT = 3'd3; lat = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(negedge CLK);
      if (k == 3) begin WSCNT = 3'd7; WR = 2'b00; end
      if (k == 6) WAIT = 1'b1;
      if (k == 8) WAIT = 1'b0;
      if (DONE) begin lat = k; g = GNT; REQ = '0; end
    end
    idle(3);
    chk("t2_latency", 32'(lat), 32'd9);
    chk("t2_gnt", 32'(g), 32'h2);
    chk("t2_wrl_clocks", 32'(n_wr), 32'd6);
    chk("t2_rdl_clocks", 32'(n_rd), 32'd0);
    chk("t2_mreql_clocks", 32'(n_mreq), 32'd1);
    $display("txn 2: wait-state write ch1, done after %0d clocks, gnt=%b", lat, g);

    // Both channels requesting continuously: alternating grants, back-to-back.
    clr(); REQ = 2'b11; WR = 2'b01; WSCNT = 3'd0; nd = 0;
    @(negedge CLK);
    n_idle = 0;
    for (int k = 0; k < 40 && nd < 4; k++) begin
      @(negedge CLK);
      if (DONE) begin
        gseq[nd] = GNT; nd++;
        if (nd == 4) REQ = '0;
      end
    end
    chk("t3_busy_gaps", 32'(n_idle), 32'd0);
    idle(3);
    chk("t3_gnt0", 32'(gseq[0]), 32'h1);
    chk("t3_gnt1", 32'(gseq[1]), 32'h2);
    chk("t3_gnt2", 32'(gseq[2]), 32'h1);
    chk("t3_gnt3", 32'(gseq[3]), 32'h2);
    chk("t3_done_count", 32'(n_done), 32'd4);
    chk("t3_wrl_clocks", 32'(n_wr), 32'd2);
    chk("t3_rdl_clocks", 32'(n_rd), 32'd2);
    $display("txn 3: round robin grants %b %b %b %b", gseq[0], gseq[1], gseq[2], gseq[3]);

    // BAK removed during ARB: cycle abandoned.
    clr(); REQ = 2'b01; WR = 2'b00; BAK = 1'b1;
    @(negedge CLK);
    chk("t4a_arb_gnt", 32'(GNT), 32'h1);
    BAK = 1'b0;
    idle(4);
    chk("t4a_mreql_clocks", 32'(n_mreq), 32'd0);
    chk("t4a_cycl_clocks", 32'(n_cycl), 32'd0);
    chk("t4a_done_count", 32'(n_done), 32'd0);
    chk("t4a_busy", 32'(BUSY), 32'd0);
    REQ = '0;
    $display("txn 4a: BAK dropped in ARB, cycle abandoned");

    // BAK and REQ removed during DATA: cycle still completes.
    clr(); REQ = 2'b01; WR = 2'b00; BAK = 1'b1; WSCNT = 3'd2; lat = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(negedge CLK);
      if (k == 3) begin BAK = 1'b0; REQ = '0; end
      if (DONE) begin lat = k; g = GNT; end
    end
    idle(3);
    chk("t4b_latency", 32'(lat), 32'd6);
    chk("t4b_gnt", 32'(g), 32'h1);
    chk("t4b_rdl_clocks", 32'(n_rd), 32'd3);
    chk("t4b_done_count", 32'(n_done), 32'd1);
    $display("txn 4b: BAK dropped in DATA, done after %0d clocks", lat);

    // Gating: WAIT high, then BAK low, with requests pending.
    clr(); REQ = 2'b11; BAK = 1'b1; WAIT = 1'b1;
    idle(4);
    WAIT = 1'b0; BAK = 1'b0;
    idle(4);
    chk("t5_busy_clocks", 32'(n_busy), 32'd0);
    chk("t5_mreql_clocks", 32'(n_mreq), 32'd0);
    REQ = '0; BAK = 1'b1;
    idle(1);
    $display("txn 5: start gated by WAIT and BAK");

    // Reset mid-DATA on a channel-0 write, then the next grant restarts at channel 0.
    clr(); REQ = 2'b01; WR = 2'b01; WSCNT = 3'd3;
    idle(3);
    chk("t6_wrl_low", 32'(WRL), 32'd0);
    RESETL = 1'b0; REQ = '0;
    @(negedge CLK);
    chk("t6_reset_outputs", 32'({GNT, MREQL, CYCL, RDL, WRL, DONE, BUSY}), 32'h3C);
    RESETL = 1'b1;
    idle(3);
    chk("t6_done_count", 32'(n_done), 32'd0);
    REQ = 2'b11; WR = 2'b00; WSCNT = 3'd0;
    wait_done(20, lat, g);
    idle(2);
    chk("t6_latency", 32'(lat), 32'd4);
    chk("t6_gnt_after_reset", 32'(g), 32'h1);
    $display("txn 6: reset mid-DATA, next grant %b", g);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dma_memcyc.md
DMA_MEMCYC -- requirements
Module: dma_memcyc

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  NCH, 2, number of DMA requester channels, legal range 1..4
  WSW, 3, width of the programmable wait-state count
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  CLK  in  1  single clock; all state changes on rising edge
  RESETL  in  1  reset, synchronous, active-low
  REQ  in  NCH  per-channel cycle request, active-high
  WR  in  NCH  per-channel direction: 1 = write, 0 = read
  BAK  in  1  bus acknowledge from host, active-high
  WAIT  in  1  external memory wait, active-high
  WSCNT  in  WSW  programmed wait states added to the DATA state
  GNT  out  NCH  one-hot channel owning the current cycle
  MREQL  out  1  memory request, active-low
  CYCL  out  1  cycle strobe, active-low during ADDR and DATA
  RDL  out  1  read strobe, active-low
  WRL  out  1  write strobe, active-low
  DONE  out  1  one-clock cycle-complete pulse
  BUSY  out  1  high in every state except IDLE
REQ-003 Reset SHALL be synchronous and active-low, applied on the CLK rising edge while RESETL = 0.

Function
REQ-004 The FSM SHALL have exactly five states: IDLE, ARB, ADDR, DATA and END.
REQ-005 All outputs SHALL be driven from flops, with no combinational path from any input to any output.
REQ-006 IDLE -> ARB SHALL occur when |REQ & BAK & ~WAIT; otherwise the FSM stays in IDLE.
REQ-007 In ARB, a round-robin grant SHALL be latched into GNT; the search starts at channel (last granted + 1) mod NCH; after reset it starts at channel 0.
REQ-008 ARB -> ADDR SHALL occur if BAK = 1; if BAK = 0 the FSM returns to IDLE, GNT clears, and DONE is not pulsed.
REQ-009 On the ARB -> ADDR transition, WSCNT and the WR bit of the granted channel SHALL be captured; later changes to either have no effect on the cycle in progress.
REQ-010 ADDR SHALL last exactly one clock, with MREQL = 0 and CYCL = 0.
REQ-011 DATA SHALL assert CYCL = 0 plus RDL = 0 (read) or WRL = 0 (write); RDL and WRL are never low together.
REQ-012 DATA SHALL last 1 + captured WSCNT clocks, then extend one clock at a time while WAIT = 1 at the final count.
REQ-013 Once ADDR is entered, the cycle SHALL complete regardless of BAK or REQ.
REQ-014 END SHALL last one clock, with DONE = 1, GNT still valid, and all strobes high.
REQ-015 END -> ARB SHALL occur (back-to-back, no IDLE) if |REQ & BAK & ~WAIT; otherwise END -> IDLE and GNT clears.
REQ-016 A requester dropping REQ after ARB SHALL NOT abort the cycle; the requester holds REQ until DONE to obtain a single cycle.
REQ-017 Latency with WSCNT = 0 and WAIT = 0: REQ sampled at edge n gives ARB at n+1, ADDR at n+2, DATA at n+3, and END/DONE at n+4.
REQ-018 With NCH = 1, arbitration SHALL degenerate to GNT = REQ[0] latched in ARB, with timing unchanged.

Reset
REQ-019 Reset SHALL set: state = IDLE; MREQL = CYCL = RDL = WRL = 1; GNT = 0; DONE = BUSY = 0; round-robin pointer = channel 0; wait counter = 0.
REQ-020 Reset asserted mid-cycle, in any state, SHALL take effect at that edge: strobes go high and no DONE is issued for the aborted cycle.

Verification
REQ-021 Single read: NCH = 2, REQ = 01, WR = 00, BAK = 1, WAIT = 0, WSCNT = 0 -> MREQL low 1 clock, CYCL low 2, RDL low 1, DONE at edge n+4, GNT = 01.
REQ-022 Wait states: WSCNT = 3, write on channel 1, WAIT high for 2 clocks at the final count -> WRL low 6 clocks, DONE one clock later, GNT = 10.
REQ-023 Round-robin: REQ = 11 held continuously -> GNT sequence 01, 10, 01, 10, END goes directly to ARB, BUSY never drops.
REQ-024 BAK removal: BAK drops during ARB -> return to IDLE, no strobes, no DONE; BAK drops during DATA -> cycle completes and DONE pulses.
REQ-025 Reset mid-DATA: RESETL = 0 for one edge while WRL = 0 -> all strobes high and GNT = 0 next clock, no DONE, next grant goes to channel 0.
REQ-026 Gating: WAIT = 1 or BAK = 0 in IDLE with REQ asserted -> FSM stays in IDLE, BUSY = 0.
